countdown_ctrl: RTL

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

---
 rtl/countdown_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: control FSM for a HH:MM:SS count-down timer.
// Drives the datapath's count enable, +1 s increment pulses (with minute and
// hour bursts in adjust mode), the datapath clear pulse and the alarm flag.
// Optional feature macro: ALARM_TIMEOUT_EN. When defined, the alarm clears
// itself after ALARM_CYCLES clock cycles. When undefined, the alarm persists
// until a button is pressed.
module countdown_ctrl #(
    parameter int ALARM_CYCLES = 10000,
    parameter int MIN_PULSES   = 60,
    parameter int HR_PULSES    = 3600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_clr,
    input  logic       btn_adj,
    input  logic       btn_inc_sec,
    input  logic       btn_inc_min,
    input  logic       btn_inc_hr,
    input  logic [7:0] seconds,
    input  logic [7:0] mins,
    input  logic [7:0] hrs,
    output logic       en,
    output logic       enc_sec,
    output logic       rst_counters,
    output logic       alarm,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADJ   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_ALARM = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] burst_cnt_q, burst_cnt_d;
    logic        busy_d, enc_d, rst_d;
    logic        zero;
    logic        p_clr, p_start, p_adj, p_hr, p_min, p_sec, any_btn;

    assign zero = (seconds == 8'd0) && (mins == 8'd0) && (hrs == 8'd0);

    // Priority decode: only the highest-priority pressed button survives.
    assign p_clr   = btn_clr;
    assign p_start = btn_start   & ~btn_clr;
    assign p_adj   = btn_adj     & ~btn_start & ~btn_clr;
    assign p_hr    = btn_inc_hr  & ~btn_adj & ~btn_start & ~btn_clr;
    assign p_min   = btn_inc_min & ~btn_inc_hr & ~btn_adj & ~btn_start & ~btn_clr;
    assign p_sec   = btn_inc_sec & ~btn_inc_min & ~btn_inc_hr & ~btn_adj & ~btn_start & ~btn_clr;
    assign any_btn = btn_clr | btn_start | btn_adj | btn_inc_hr | btn_inc_min | btn_inc_sec;

    assign state = state_q;

`ifdef ALARM_TIMEOUT_EN
    logic [13:0] alarm_cnt_q, alarm_cnt_d;
    logic        alarm_done;

    // The counter holds 0 on the first alarm cycle, so the last cycle is ALARM_CYCLES-1.
    assign alarm_done = (alarm_cnt_q == 14'(ALARM_CYCLES - 1));
`endif

    // Next-state, burst sequencing and next registered-output values.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = 12'd0;
        busy_d      = 1'b0;
        enc_d       = 1'b0;
        rst_d       = 1'b0;
`ifdef ALARM_TIMEOUT_EN
        alarm_cnt_d = 14'd0;
`endif
        case (state_q)
            S_IDLE: begin
                if (p_clr)                 rst_d   = 1'b1;
                else if (p_start && !zero) state_d = S_RUN;
                else if (p_adj)            state_d = S_ADJ;
            end
            S_ADJ: begin
                if (busy) begin
                    // Mid-burst only a clear is honoured; it aborts the burst.
                    if (p_clr) begin
                        rst_d = 1'b1;
                    end else if (burst_cnt_q != 12'd0) begin
                        burst_cnt_d = burst_cnt_q - 12'd1;
                        busy_d      = 1'b1;
                        enc_d       = 1'b1;
                    end
                end else begin
                    if (p_clr) begin
                        rst_d = 1'b1;
                    end else if (p_start && !zero) begin
                        state_d = S_RUN;
                    end else if (p_adj) begin
                        state_d = S_IDLE;
                    end else if (p_hr) begin
                        burst_cnt_d = 12'(HR_PULSES - 1);
                        busy_d      = 1'b1;
                        enc_d       = 1'b1;
                    end else if (p_min) begin
                        burst_cnt_d = 12'(MIN_PULSES - 1);
                        busy_d      = 1'b1;
                        enc_d       = 1'b1;
                    end else if (p_sec) begin
                        burst_cnt_d = 12'd0;
                        busy_d      = 1'b1;
                        enc_d       = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (p_clr) begin
                    state_d = S_IDLE;
                    rst_d   = 1'b1;
                end else if (p_start) begin
                    state_d = S_PAUSE;
                end else if (zero) begin
                    state_d = S_ALARM;
                end
            end
            S_PAUSE: begin
                if (p_clr) begin
                    state_d = S_IDLE;
                    rst_d   = 1'b1;
                end else if (p_start) begin
                    state_d = S_RUN;
                end else if (p_adj) begin
                    state_d = S_ADJ;
                end
            end
            S_ALARM: begin
                if (any_btn) begin
                    state_d = S_IDLE;
                    rst_d   = p_clr;
                end
`ifdef ALARM_TIMEOUT_EN
                else if (alarm_done) begin
                    state_d = S_IDLE;
                end else begin
                    alarm_cnt_d = alarm_cnt_q + 14'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, burst counter and all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            burst_cnt_q  <= 12'd0;
            en           <= 1'b0;
            enc_sec      <= 1'b0;
            rst_counters <= 1'b0;
            alarm        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            en           <= (state_d == S_RUN);
            enc_sec      <= enc_d;
            rst_counters <= rst_d;
            alarm        <= (state_d == S_ALARM);
            busy         <= busy_d;
        end
    end

`ifdef ALARM_TIMEOUT_EN
    // Alarm timeout counter; held at zero outside ALARM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alarm_cnt_q <= 14'd0;
        else        alarm_cnt_q <= alarm_cnt_d;
    end
`endif

endmodule
